alu_muldiv_seq: RTL and testbench

//  Multi-cycle sequencer for MUL, DIVU and REMU, built on the shared 32-bit ALU.
//  It issues one ALU operation per cycle (ADD, SUB or unsigned >=) and does all shifts locally.
//  It sits beside the EX stage; while alu_claim=1 the EX mux hands the ALU to this block.

---
 rtl/alu_muldiv_seq_pkg.sv | 32 +++
 rtl/alu_muldiv_seq_if.sv | 30 +++
 rtl/alu_muldiv_seq.sv | 152 +++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the multi-cycle MUL/DIVU/REMU sequencer.
package muldiv_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b1001;
  localparam logic [3:0] ALU_GEU = 4'b0110;

  typedef enum logic [1:0] {
    MD_MUL  = 2'b00,
    MD_DIVU = 2'b01,
    MD_REMU = 2'b10
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DCMP,
    ST_DSUB,
    ST_DONE
  } muldiv_state_e;

  // The reserved encoding 2'b11 behaves as MUL.
  function automatic muldiv_op_e decode_op(input logic [1:0] op);
    case (op)
      2'b01:   return MD_DIVU;
      2'b10:   return MD_REMU;
      default: return MD_MUL;
    endcase
  endfunction

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/response handshake plus the borrowed-ALU port bundle.
interface alu_muldiv_seq_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);
  logic                     start;
  logic [1:0]               op;
  logic [DATA_WIDTH-1:0]    operand_a;
  logic [DATA_WIDTH-1:0]    operand_b;
  logic                     busy;
  logic                     done;
  logic [DATA_WIDTH-1:0]    result;
  logic                     alu_claim;
  logic [DATA_WIDTH-1:0]    alu_srca;
  logic [DATA_WIDTH-1:0]    alu_srcb;
  logic [OPCODE_LENGTH-1:0] alu_operation;
  logic [DATA_WIDTH-1:0]    alu_result;

  // requester + datapath ALU side
  modport master (
    output start, op, operand_a, operand_b, alu_result,
    input  busy, done, result, alu_claim, alu_srca, alu_srcb, alu_operation
  );

  // sequencer side
  modport slave (
    input  start, op, operand_a, operand_b, alu_result,
    output busy, done, result, alu_claim, alu_srca, alu_srcb, alu_operation
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Shift-add multiplier and restoring divider that borrow the EX-stage ALU
// for one ADD/SUB/GEU per cycle; all shifting happens locally.
module alu_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input logic             clk,
  input logic             reset,
  alu_muldiv_seq_if.slave bus
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  muldiv_state_e         state;
  muldiv_op_e            op_q;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] acc, mc, mp;
  logic [DATA_WIDTH-1:0] rem, q, d;
  logic                  ge;

  logic [DATA_WIDTH-1:0] rs, acc_nxt, rem_nxt, q_nxt;
  logic                  last;

  // Datapath helpers: shifted remainder for the compare step and the
  // values each iteration would commit.
  always_comb begin
    rs      = {rem[DATA_WIDTH-2:0], q[DATA_WIDTH-1]};
    acc_nxt = mp[0] ? bus.alu_result : acc;
    rem_nxt = ge ? bus.alu_result : rem;
    q_nxt   = {q[DATA_WIDTH-1:1], q[0] | ge};
    last    = (cnt == CNT_LAST);
  end

  // ALU request decoded from the current state; the ALU is released
  // (zero operands, AND opcode) whenever no compute state is active.
  always_comb begin
    bus.alu_claim     = 1'b0;
    bus.alu_srca      = '0;
    bus.alu_srcb      = '0;
    bus.alu_operation = OPCODE_LENGTH'(ALU_AND);
    case (state)
      ST_MUL: begin
        bus.alu_claim     = 1'b1;
        bus.alu_srca      = acc;
        bus.alu_srcb      = mc;
        bus.alu_operation = OPCODE_LENGTH'(ALU_ADD);
      end
      ST_DCMP: begin
        bus.alu_claim     = 1'b1;
        bus.alu_srca      = rs;
        bus.alu_srcb      = d;
        bus.alu_operation = OPCODE_LENGTH'(ALU_GEU);
      end
      ST_DSUB: begin
        bus.alu_claim     = 1'b1;
        bus.alu_srca      = rem;
        bus.alu_srcb      = d;
        bus.alu_operation = OPCODE_LENGTH'(ALU_SUB);
      end
      default: ;
    endcase
  end

  // Sequencer FSM with registered busy/done/result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_q       <= MD_MUL;
      cnt        <= '0;
      acc        <= '0;
      mc         <= '0;
      mp         <= '0;
      rem        <= '0;
      q          <= '0;
      d          <= '0;
      ge         <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
          op_q     <= decode_op(bus.op);
          cnt      <= '0;
          bus.busy <= 1'b1;
          if (decode_op(bus.op) == MD_MUL) begin
            acc   <= '0;
            mc    <= bus.operand_a;
            mp    <= bus.operand_b;
            state <= ST_MUL;
          end else if (bus.operand_b != '0) begin
            rem   <= '0;
            q     <= bus.operand_a;
            d     <= bus.operand_b;
            state <= ST_DCMP;
          end else begin
            q     <= '1;
            rem   <= bus.operand_a;
            state <= ST_DONE;
          end
        end
        ST_MUL: begin
          acc <= acc_nxt;
          mc  <= mc << 1;
          mp  <= mp >> 1;
          cnt <= cnt + CW'(1);
          if (last) begin
            bus.result <= acc_nxt;
            bus.done   <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DCMP: begin
          // rem[MSB] is the 33rd bit of the shifted remainder: if set, rs >= d.
          ge    <= rem[DATA_WIDTH-1] | bus.alu_result[0];
          q     <= q << 1;
          rem   <= rs;
          state <= ST_DSUB;
        end
        ST_DSUB: begin
          rem <= rem_nxt;
          q   <= q_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            bus.result <= (op_q == MD_REMU) ? rem_nxt : q_nxt;
            bus.done   <= 1'b1;
            state      <= ST_DONE;
          end else begin
            state <= ST_DCMP;
          end
        end
        ST_DONE: begin
          // Divide-by-zero arrives here without done set; it publishes its
          // result one cycle later, others leave right after the pulse.
          if (bus.done) begin
            bus.done <= 1'b0;
            bus.busy <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            bus.result <= (op_q == MD_REMU) ? rem : q;
            bus.done   <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench: directed table, corner sequences and random ops
// against an arithmetic reference, with a behavioural ALU on the alu_* ports.
module tb_alu_muldiv_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_muldiv_seq_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus ();

  alu_muldiv_seq #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural datapath ALU
  always_comb begin
    case (bus.alu_operation)
      4'b0000: bus.alu_result = bus.alu_srca & bus.alu_srcb;
      4'b0011: bus.alu_result = bus.alu_srca + bus.alu_srcb;
      4'b1001: bus.alu_result = bus.alu_srca - bus.alu_srcb;
      4'b0110: bus.alu_result = {31'b0, bus.alu_srca >= bus.alu_srcb};
      default: bus.alu_result = 32'h0;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : a % b;
      default: begin p = 64'(a) * 64'(b); return p[31:0]; end
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] b);
    if (op == 2'b01 || op == 2'b10) return (b == 0) ? 2 : 65;
    return 33;
  endfunction

  // Issue one op at a negedge; cycle n = period after the n-th rising edge
  // counting the accept edge as edge 0. Optionally pulse start mid-run.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int pulse_cyc,
                        output logic [31:0] res, output int lat,
                        output int busy_low, output bit claim_seen);
    int cyc;
    busy_low = 0; claim_seen = 0; lat = -1; res = 'x;
    bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 200) begin
      if (!bus.busy) busy_low++;
      if (bus.alu_claim) claim_seen = 1;
      if (bus.done) begin
        lat = cyc; res = bus.result;
        break;
      end
      if (cyc == pulse_cyc) begin
        bus.start = 1'b1; bus.op = 2'b01; bus.operand_a = 32'h1234; bus.operand_b = 32'h3;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] res;
    int lat, blow, hits;
    bit claim;
    logic [1:0] rop;
    logic [31:0] ra, rb;

    vecs[0] = '{2'b00, 32'd6,          32'd7,          32'd42,         33};
    vecs[1] = '{2'b00, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  33};
    vecs[2] = '{2'b01, 32'd100,        32'd7,          32'd14,         65};
    vecs[3] = '{2'b10, 32'd100,        32'd7,          32'd2,          65};
    vecs[4] = '{2'b01, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          65};
    vecs[5] = '{2'b10, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  65};
    vecs[6] = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  2};
    vecs[7] = '{2'b10, 32'd5,          32'd0,          32'd5,          2};
    vecs[8] = '{2'b11, 32'd3,          32'd5,          32'd15,         33};
    vecs[9] = '{2'b01, 32'd7,          32'd100,        32'd0,          65};

    bus.start = 1'b0; bus.op = 2'b00; bus.operand_a = '0; bus.operand_b = '0;
    repeat (3) @(negedge clk);
    // reset state
    chk("rst_busy",  {31'b0, bus.busy},      32'h0);
    chk("rst_done",  {31'b0, bus.done},      32'h0);
    chk("rst_result", bus.result,            32'h0);
    chk("rst_claim", {31'b0, bus.alu_claim}, 32'h0);
    chk("rst_srca",  bus.alu_srca,           32'h0);
    chk("rst_srcb",  bus.alu_srcb,           32'h0);
    chk("rst_aluop", {28'b0, bus.alu_operation}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, res, lat, blow, claim);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_busy_low", i), blow, 0);
      chk($sformatf("vec%0d_claim", i), {31'b0, claim}, {31'b0, vecs[i].lat != 2});
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), {31'b0, bus.done}, 32'h0);
      chk($sformatf("vec%0d_busy_after", i), {31'b0, bus.busy}, 32'h0);
      chk($sformatf("vec%0d_result_hold", i), bus.result, vecs[i].exp);
    end

    // start pulses while busy and in the DONE cycle are ignored
    run_op(2'b00, 32'd123, 32'd1000, 5, res, lat, blow, claim);
    chk("ign_result", res, 32'd123000);
    chk("ign_latency", lat, 33);
    bus.start = 1'b1; bus.op = 2'b01; bus.operand_a = 32'd9; bus.operand_b = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    hits = 0;
    repeat (80) begin
      if (bus.done || bus.busy) hits++;
      @(negedge clk);
    end
    chk("ign_done_start", hits, 0);
    chk("ign_result_hold", bus.result, 32'd123000);

    // reset in cycle 10 of a MUL
    bus.start = 1'b1; bus.op = 2'b00; bus.operand_a = 32'd11; bus.operand_b = 32'd13;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mrst_busy",   {31'b0, bus.busy},      32'h0);
    chk("mrst_result", bus.result,             32'h0);
    chk("mrst_claim",  {31'b0, bus.alu_claim}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    hits = 0;
    repeat (40) begin
      if (bus.done || bus.busy || bus.alu_claim) hits++;
      @(negedge clk);
    end
    chk("mrst_quiet", hits, 0);
    run_op(2'b00, 32'd11, 32'd13, -1, res, lat, blow, claim);
    chk("mrst_next_result", res, 32'd143);
    chk("mrst_next_latency", lat, 33);
    @(negedge clk);

    // random ops against the arithmetic reference
    for (int n = 0; n < 24; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, -1, res, lat, blow, claim);
      chk($sformatf("rnd%0d_op%0d_%h_%h_result", n, rop, ra, rb), res, ref_result(rop, ra, rb));
      chk($sformatf("rnd%0d_latency", n), lat, ref_latency(rop, rb));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
